// File: rtl/sdf_stage_ctrl_if.sv
// Sample stream (valid strobe + data word) passed between chained SDF stages.
interface sdf_stage_ctrl_if #(
  parameter int unsigned DataWidth = 64
);
  logic                 valid;
  logic [DataWidth-1:0] data;

  modport master (output valid, output data);
  modport slave  (input  valid, input  data);
endinterface

// File: rtl/sdf_stage_ctrl.sv
// Radix-2 SDF stage wrapper: feedback delay line, frame phase counter and twiddle address for one bfu.
// Define SDF_OUT_REG_EN to add a second output register stage (2-clock latency).
module sdf_stage_ctrl #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Modulo    = 7681,
  parameter int unsigned NPoints   = 64,
  parameter int unsigned Depth     = 32,
  localparam int unsigned CntW     = $clog2(2 * Depth),
  localparam int unsigned TwW      = $clog2(NPoints / 2)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sdf_stage_ctrl_if.slave      i_in,
  sdf_stage_ctrl_if.master     o_out,
  output logic [TwW-1:0]       o_tw_addr,
  output logic [DataWidth-1:0] o_bf_a,
  output logic [DataWidth-1:0] o_bf_b,
  input  logic [DataWidth-1:0] i_bf_sum,
  input  logic [DataWidth-1:0] i_bf_diff
);

  localparam int unsigned Stride = NPoints / (2 * Depth);

  if (Modulo < 2 || (Depth & (Depth - 1)) != 0 || Depth > NPoints / 2) begin : g_bad_cfg
    $error("sdf_stage_ctrl: invalid Modulo/Depth/NPoints combination");
  end

  logic [CntW-1:0]      r_cnt;
  logic                 r_primed;
  logic [DataWidth-1:0] r_dl [Depth];
  logic                 r_out_valid;
  logic [DataWidth-1:0] r_out_data;

  logic                 w_compute;
  logic [DataWidth-1:0] w_head;
  logic [DataWidth-1:0] w_dl_in;
  logic [DataWidth-1:0] w_out_d;
  logic                 w_at_half;
  logic                 w_out_valid_d;
  logic [TwW-1:0]       w_tw;

  // Counter MSB marks the second half of the frame.
  assign w_compute = r_cnt[CntW-1];
  assign w_head    = r_dl[Depth-1];
  assign w_at_half = (r_cnt == CntW'(Depth));

  always_comb begin
    w_dl_in       = i_in.data;
    w_out_d       = w_head;
    w_tw          = '0;
    w_out_valid_d = i_in.valid & (r_primed | w_at_half);
    if (w_compute) begin
      w_dl_in = i_bf_diff;
      w_out_d = i_bf_sum;
      w_tw    = TwW'((32'(r_cnt) - Depth) * Stride);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_out_valid_d;
      if (i_in.valid) begin
        r_cnt      <= r_cnt + CntW'(1);
        r_out_data <= w_out_d;
        if (w_at_half) r_primed <= 1'b1;
      end
    end
  end

  // Head (highest index) is the oldest entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < Depth; i++) r_dl[i] <= '0;
    end else if (i_in.valid) begin
      r_dl[0] <= w_dl_in;
      for (int unsigned i = 1; i < Depth; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  assign o_tw_addr = w_tw;
  assign o_bf_a    = w_head;
  assign o_bf_b    = i_in.data;

`ifdef SDF_OUT_REG_EN
  logic                 r_out2_valid;
  logic [DataWidth-1:0] r_out2_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out2_valid <= 1'b0;
      r_out2_data  <= '0;
    end else begin
      r_out2_valid <= r_out_valid;
      if (r_out_valid) r_out2_data <= r_out_data;
    end
  end

  assign o_out.valid = r_out2_valid;
  assign o_out.data  = r_out2_data;
`else
  assign o_out.valid = r_out_valid;
  assign o_out.data  = r_out_data;
`endif

endmodule
